// File: rtl/branch_unit_pkg.sv
// Shared types for the branch unit: compare-function encoding and redirect message.
package branch_unit_pkg;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_func_e;

  // Widest sequence tag the redirect message can carry.
  localparam int unsigned BU_MAX_SEQ_BITS = 16;

  typedef struct packed {
    logic [31:0]                target;
    logic [BU_MAX_SEQ_BITS-1:0] seq_num;
  } redirect_msg_t;

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [31:0] imm);
    return pc + imm;
  endfunction

endpackage

// File: rtl/branch_unit_cmp.sv
// Combinational branch condition evaluation; encodings outside br_func_e resolve not-taken.
module branch_unit_cmp
  import branch_unit_pkg::*;
(
  input  br_func_e    i_func,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  output logic        o_taken
);

  logic w_eq;
  logic w_lt;
  logic w_ltu;

  assign w_eq  = (i_op1 == i_op2);
  assign w_lt  = ($signed(i_op1) < $signed(i_op2));
  assign w_ltu = (i_op1 < i_op2);

  always_comb begin
    o_taken = 1'b0;
    case (i_func)
      BR_BEQ:  o_taken = w_eq;
      BR_BNE:  o_taken = ~w_eq;
      BR_BLT:  o_taken = w_lt;
      BR_BGE:  o_taken = ~w_lt;
      BR_BLTU: o_taken = w_ltu;
      BR_BGEU: o_taken = ~w_ltu;
      default: o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Elastic branch-resolution pipeline with predict-not-taken redirect on completion.
// Optional completion counters are enabled by defining BRANCH_UNIT_STATS_EN.
module branch_unit
  import branch_unit_pkg::*;
#(
  parameter int p_seq_num_bits = 5,
  parameter int p_num_stages   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_val,
  output logic                      in_rdy,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_op1,
  input  logic [31:0]               in_op2,
  input  logic [31:0]               in_imm,
  input  logic [2:0]                in_func,
  input  logic [p_seq_num_bits-1:0] in_seq_num,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [p_seq_num_bits-1:0] out_seq_num,
  output logic                      out_taken,
  output logic                      redirect_val,
  output logic [31:0]               redirect_target,
  output logic [p_seq_num_bits-1:0] redirect_seq_num,
  input  logic                      squash
`ifdef BRANCH_UNIT_STATS_EN
  ,
  output logic [31:0]               stat_taken,
  output logic [31:0]               stat_not_taken
`endif
);

  localparam int LAST = p_num_stages - 1;

  generate
    if (p_num_stages < 1 || p_num_stages > 4) begin : g_bad_stages
      $error("branch_unit: p_num_stages must be in 1..4");
    end
    if (p_seq_num_bits < 1 || p_seq_num_bits > BU_MAX_SEQ_BITS) begin : g_bad_seq
      $error("branch_unit: p_seq_num_bits out of range");
    end
  endgenerate

  logic [p_num_stages-1:0]   r_val;
  logic [p_num_stages-1:0]   r_taken;
  logic [p_seq_num_bits-1:0] r_seq    [p_num_stages];
  logic [31:0]               r_target [p_num_stages];

  logic [p_num_stages:0]     w_ready;
  logic [p_num_stages-1:0]   w_adv;
  logic [p_num_stages-1:0]   w_src_val;
  logic [p_num_stages-1:0]   w_src_taken;
  logic [p_seq_num_bits-1:0] w_src_seq    [p_num_stages];
  logic [31:0]               w_src_target [p_num_stages];

  logic          w_in_xfer;
  logic          w_cmp_taken;
  logic          w_out_fire;
  logic          w_unused_seq_hi;
  redirect_msg_t w_redirect;

  branch_unit_cmp u_cmp (
    .i_func  (br_func_e'(in_func)),
    .i_op1   (in_op1),
    .i_op2   (in_op2),
    .o_taken (w_cmp_taken)
  );

  // Ready ripples back from the consumer; bit N is the sink.
  always_comb begin
    w_ready = '0;
    w_adv   = '0;
    w_ready[p_num_stages] = out_rdy & rst_n;
    for (int k = p_num_stages - 1; k >= 0; k--) begin
      w_adv[k]   = r_val[k] & w_ready[k+1];
      w_ready[k] = ~r_val[k] | w_adv[k];
    end
  end

  assign in_rdy     = w_ready[0] & ~squash & rst_n;
  assign w_in_xfer  = in_val & in_rdy;
  assign out_val    = r_val[LAST] & rst_n;
  assign w_out_fire = out_val & out_rdy;

  genvar gi;
  generate
    for (gi = 0; gi < p_num_stages; gi++) begin : g_src
      if (gi == 0) begin : g_head
        assign w_src_val[gi]    = w_in_xfer;
        assign w_src_taken[gi]  = w_cmp_taken;
        assign w_src_seq[gi]    = in_seq_num;
        assign w_src_target[gi] = branch_target(in_pc, in_imm);
      end else begin : g_body
        assign w_src_val[gi]    = w_adv[gi-1];
        assign w_src_taken[gi]  = r_taken[gi-1];
        assign w_src_seq[gi]    = r_seq[gi-1];
        assign w_src_target[gi] = r_target[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n || squash) begin
      r_val <= '0;
    end else begin
      for (int k = 0; k < p_num_stages; k++) begin
        if (w_ready[k]) r_val[k] <= w_src_val[k];
      end
    end
  end

  // Payload carries no reset; it is only meaningful under the matching valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < p_num_stages; k++) begin
      if (w_ready[k]) begin
        r_taken[k]  <= w_src_taken[k];
        r_seq[k]    <= w_src_seq[k];
        r_target[k] <= w_src_target[k];
      end
    end
  end

  assign out_seq_num        = r_seq[LAST];
  assign out_taken          = r_taken[LAST];
  assign w_redirect.target  = r_target[LAST];
  assign w_redirect.seq_num = BU_MAX_SEQ_BITS'(r_seq[LAST]);
  assign w_unused_seq_hi    = ^w_redirect.seq_num;

  assign redirect_val     = w_out_fire & r_taken[LAST];
  assign redirect_target  = w_redirect.target;
  assign redirect_seq_num = w_redirect.seq_num[p_seq_num_bits-1:0];

`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0] r_stat_taken;
  logic [31:0] r_stat_not_taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stat_taken     <= '0;
      r_stat_not_taken <= '0;
    end else if (w_out_fire) begin
      if (r_taken[LAST]) r_stat_taken     <= r_stat_taken + 32'd1;
      else               r_stat_not_taken <= r_stat_not_taken + 32'd1;
    end
  end

  assign stat_taken     = r_stat_taken;
  assign stat_not_taken = r_stat_not_taken;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit (3 stages); stats ports checked when BRANCH_UNIT_STATS_EN is defined.
module tb_branch_unit;
  import branch_unit_pkg::*;

  localparam int NS = 3;
  localparam int SB = 5;

  logic          clk;
  logic          rst_n;
  logic          in_val;
  logic          in_rdy;
  logic [31:0]   in_pc;
  logic [31:0]   in_op1;
  logic [31:0]   in_op2;
  logic [31:0]   in_imm;
  logic [2:0]    in_func;
  logic [SB-1:0] in_seq_num;
  logic          out_val;
  logic          out_rdy;
  logic [SB-1:0] out_seq_num;
  logic          out_taken;
  logic          redirect_val;
  logic [31:0]   redirect_target;
  logic [SB-1:0] redirect_seq_num;
  logic          squash;
`ifdef BRANCH_UNIT_STATS_EN
  logic [31:0]   stat_taken;
  logic [31:0]   stat_not_taken;
`endif

  branch_unit #(.p_seq_num_bits(SB), .p_num_stages(NS)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_val           (in_val),
    .in_rdy           (in_rdy),
    .in_pc            (in_pc),
    .in_op1           (in_op1),
    .in_op2           (in_op2),
    .in_imm           (in_imm),
    .in_func          (in_func),
    .in_seq_num       (in_seq_num),
    .out_val          (out_val),
    .out_rdy          (out_rdy),
    .out_seq_num      (out_seq_num),
    .out_taken        (out_taken),
    .redirect_val     (redirect_val),
    .redirect_target  (redirect_target),
    .redirect_seq_num (redirect_seq_num),
    .squash           (squash)
`ifdef BRANCH_UNIT_STATS_EN
    ,
    .stat_taken       (stat_taken),
    .stat_not_taken   (stat_not_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SB-1:0] seq;
    logic          taken;
    logic [31:0]   target;
    int            acc;
    bit            chk_lat;
  } exp_t;

  typedef struct {
    logic [2:0]  f;
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } vec_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          chk_lat_cur = 1'b0;
  logic [SB-1:0] seq_cnt = '0;
  logic [31:0] exp_st_taken = '0;
  logic [31:0] exp_st_nt = '0;
  vec_t        vecs[12];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Monitor: reset checks, completion scoreboard, squash flush, acceptance push.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check_val("rst_out_val", 32'(out_val), 32'd0);
      check_val("rst_redirect_val", 32'(redirect_val), 32'd0);
      check_val("rst_in_rdy", 32'(in_rdy), 32'd0);
      sb.delete();
      exp_st_taken = '0;
      exp_st_nt    = '0;
    end else begin
      if (out_val && out_rdy) begin
        if (sb.size() == 0) begin
          check_val("spurious_completion", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check_val("out_seq_num", 32'(out_seq_num), 32'(e.seq));
          check_val("out_taken", 32'(out_taken), 32'(e.taken));
          check_val("redirect_val", 32'(redirect_val), 32'(e.taken));
          if (e.taken) begin
            check_val("redirect_target", redirect_target, e.target);
            check_val("redirect_seq_num", 32'(redirect_seq_num), 32'(e.seq));
            exp_st_taken = exp_st_taken + 32'd1;
          end else begin
            exp_st_nt = exp_st_nt + 32'd1;
          end
          if (e.chk_lat) check_val("latency", 32'(cyc - e.acc), 32'(NS));
          $display("complete seq=%0d taken=%0d target=0x%08h cycle=%0d",
                   out_seq_num, out_taken, redirect_target, cyc);
        end
      end else if (out_val) begin
        check_val("stall_no_redirect", 32'(redirect_val), 32'd0);
      end
      if (squash) sb.delete();
      if (in_val && in_rdy) begin
        e.seq     = in_seq_num;
        e.taken   = model_taken(in_func, in_op1, in_op2);
        e.target  = in_pc + in_imm;
        e.acc     = cyc;
        e.chk_lat = chk_lat_cur;
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [31:0] pc, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm, output int waited);
    in_val     = 1'b1;
    in_func    = f;
    in_pc      = pc;
    in_op1     = a;
    in_op2     = b;
    in_imm     = imm;
    in_seq_num = seq_cnt;
    waited     = 0;
    @(negedge clk);
    while (!in_rdy && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!in_rdy) check_val("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_val  = 1'b0;
    seq_cnt = seq_cnt + 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

`ifdef BRANCH_UNIT_STATS_EN
  task automatic check_stats(input string tag);
    check_val({tag, "_stat_taken"}, stat_taken, exp_st_taken);
    check_val({tag, "_stat_not_taken"}, stat_not_taken, exp_st_nt);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [31:0] a;
    logic [31:0] b;

    rst_n = 1'b0; in_val = 1'b0; out_rdy = 1'b1; squash = 1'b0;
    in_pc = '0; in_op1 = '0; in_op2 = '0; in_imm = '0; in_func = '0; in_seq_num = '0;

    vecs[0]  = '{BR_BGE,  32'h0000_0200, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0010};
    vecs[1]  = '{BR_BGEU, 32'h0000_0200, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0010};
    vecs[2]  = '{BR_BEQ,  32'h0000_0300, 32'h0000_0005, 32'h0000_0005, 32'h0000_0008};
    vecs[3]  = '{BR_BNE,  32'h0000_0300, 32'h0000_0005, 32'h0000_0005, 32'h0000_0008};
    vecs[4]  = '{BR_BLT,  32'h0000_0400, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0040};
    vecs[5]  = '{BR_BLTU, 32'h0000_0400, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0040};
    vecs[6]  = '{3'b010,  32'h0000_0500, 32'h0000_0007, 32'h0000_0007, 32'h0000_0004};
    vecs[7]  = '{3'b011,  32'h0000_0500, 32'h0000_0001, 32'h0000_0002, 32'h0000_0004};
    vecs[8]  = '{BR_BLT,  32'h0000_0600, 32'h0000_0003, 32'h0000_0003, 32'h0000_0004};
    vecs[9]  = '{BR_BGE,  32'h0000_0700, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0100};
    vecs[10] = '{BR_BEQ,  32'hFFFF_FFF0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0020};
    vecs[11] = '{BR_BNE,  32'h0000_1000, 32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFF8};

    // Reset, then ready on the first cycle out of reset.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("in_rdy_after_reset", 32'(in_rdy), 32'd1);
    check_val("out_val_after_reset", 32'(out_val), 32'd0);
    @(posedge clk); #1;

    // Taken BGE on equal negatives; target 0x120.
    chk_lat_cur = 1'b1;
    send(BR_BGE, 32'h100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h20, w);
    drain();

    // Directed compare/target table, back to back.
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].f, vecs[i].pc, vecs[i].a, vecs[i].b, vecs[i].imm, w);
    end
    drain();

    // Eight back-to-back random requests with no stalls.
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      send(3'($urandom_range(0, 7)), $urandom, a, b, $urandom, w);
      check_val("burst_no_stall", 32'(w), 32'd0);
    end
    drain();

    // Backpressure with the pipe full.
    chk_lat_cur = 1'b0;
    out_rdy = 1'b0;
    send(BR_BEQ, 32'h800, 32'h9, 32'h9, 32'h44, w);
    for (int i = 1; i < NS; i++) send(BR_BNE, 32'h900, 32'h1, 32'h1, 32'h4, w);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("full_in_rdy", 32'(in_rdy), 32'd0);
      check_val("full_out_val", 32'(out_val), 32'd1);
      check_val("full_seq_stable", 32'(out_seq_num), 32'(sb[0].seq));
      check_val("full_taken_stable", 32'(out_taken), 32'(sb[0].taken));
    end
    @(posedge clk); #1;
    out_rdy = 1'b1;
    drain();

    // Squash with two entries in flight and no consumer.
    out_rdy = 1'b0;
    send(BR_BEQ, 32'hA00, 32'h3, 32'h3, 32'h10, w);
    send(BR_BNE, 32'hB00, 32'h3, 32'h4, 32'h10, w);
    idle(1);
    squash = 1'b1;
    @(negedge clk);
    check_val("squash_cycle_out_val", 32'(out_val), 32'd1);
    check_val("squash_cycle_in_rdy", 32'(in_rdy), 32'd0);
    @(posedge clk); #1;
    squash = 1'b0;
    @(negedge clk);
    check_val("post_squash_out_val", 32'(out_val), 32'd0);
    check_val("post_squash_redirect", 32'(redirect_val), 32'd0);
`ifdef BRANCH_UNIT_STATS_EN
    check_stats("post_squash");
`endif
    @(posedge clk); #1;
    out_rdy = 1'b1;
    idle(5);

    // Squash coinciding with a completion: head reported, rest dropped.
    out_rdy = 1'b0;
    send(BR_BEQ, 32'hC00, 32'h5, 32'h5, 32'h80, w);
    for (int i = 1; i < NS; i++) send(BR_BEQ, 32'hD00, 32'h6, 32'h6, 32'h80, w);
    squash = 1'b1;
    out_rdy = 1'b1;
    @(posedge clk); #1;
    squash = 1'b0;
    @(negedge clk);
    check_val("squash_fire_out_val", 32'(out_val), 32'd0);
    @(posedge clk); #1;
    idle(4);

    // Reset mid-stream: nothing old completes, new work does.
    out_rdy = 1'b0;
    send(BR_BEQ, 32'hE00, 32'h1, 32'h1, 32'h8, w);
    send(BR_BEQ, 32'hE10, 32'h1, 32'h1, 32'h8, w);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_rdy = 1'b1;
    @(negedge clk);
    check_val("mid_reset_in_rdy", 32'(in_rdy), 32'd1);
    check_val("mid_reset_out_val", 32'(out_val), 32'd0);
    @(posedge clk); #1;
    idle(5);
    chk_lat_cur = 1'b1;
    send(BR_BGEU, 32'hF00, 32'hFFFF_FFFE, 32'h1, 32'h100, w);
    drain();
    idle(2);
`ifdef BRANCH_UNIT_STATS_EN
    check_stats("final");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
